// File: rtl/ac_motor_pkg.sv
// ac_motor_pkg: shared widths, quadrant and carrier-direction types for the AC motor reference generator
package ac_motor_pkg;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  function automatic int calc_w(int bits, int level_bits);
    return bits + level_bits;
  endfunction
  function automatic longint calc_tri_max(int w);
    return longint'(1) << (w - 1);
  endfunction
endpackage

// File: rtl/ac_motor_sine_rom.sv
// ac_motor_sine_rom: quarter-wave sine magnitude ROM, one-cycle read latency
// clk/rst: clock and async active-high reset; addr: quarter-wave index; mag: unsigned magnitude
module ac_motor_sine_rom #(
  parameter int BITS = 12,
  parameter int LUT_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LUT_ADDR_BITS-3:0] addr,
  output logic [BITS-2:0]          mag
);
  localparam int N = 2 ** (LUT_ADDR_BITS - 2);
  // half-index offset keeps the table symmetric so mirroring needs no special end cases
  function automatic logic [BITS-2:0] entry(int i);
    real a;
    a = ((2.0 ** (BITS - 1)) - 1.0) * $sin(3.14159265358979323846 / 2.0 * (i + 0.5) / N);
    return (BITS - 1)'($rtoi(a + 0.5));
  endfunction
  logic [BITS-2:0] rom [N];
  logic [BITS-2:0] mag_q, mag_d;
  for (genvar i = 0; i < N; i++) begin : g_rom
    localparam logic [BITS-2:0] V = entry(i);
    assign rom[i] = V;
  end
  always_comb mag_d = rom[addr];
  always_ff @(posedge clk or posedge rst)
    if (rst) mag_q <= '0;
    else mag_q <= mag_d;
  assign mag = mag_q;
endmodule

// File: rtl/ac_motor_reference_gen.sv
// ac_motor_reference_gen: triangle carrier and regular-sampled scaled sine references for the PWM comparator
// CLK/RESET: clock, async active-high reset; ENABLE: run/freeze; FREQ: phase step per carrier period;
// LEVEL: sine amplitude; TRIANGLE: signed carrier; SINE: signed modulating sample; VALLEY: carrier valley pulse.
// Optional AC_MOTOR_SOFT_START_EN: amplitude ramps toward LEVEL by one step per valley.
module ac_motor_reference_gen
  import ac_motor_pkg::*;
#(
  parameter int BITS = 12,
  parameter int LEVEL_BITS = 12,
  parameter int PHASE_BITS = 24,
  parameter int LUT_ADDR_BITS = 8,
  parameter int STEP_SHIFT = 14
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              ENABLE,
  input  logic [PHASE_BITS-1:0]             FREQ,
  input  logic [LEVEL_BITS-1:0]             LEVEL,
  output logic signed [BITS+LEVEL_BITS:0]   TRIANGLE,
  output logic signed [BITS+LEVEL_BITS-1:0] SINE,
  output logic                              VALLEY
);
  localparam int W = calc_w(BITS, LEVEL_BITS);
  localparam longint TRI_MAX = calc_tri_max(W);
  localparam logic signed [W:0] TMAX = (W + 1)'(TRI_MAX);
  localparam logic signed [W:0] STEP = (W + 1)'(longint'(1) << STEP_SHIFT);
  localparam int Q = LUT_ADDR_BITS - 2;
  if (TRI_MAX % (longint'(1) << STEP_SHIFT) != 0) begin : g_step_check
    $error("TRI_MAX must be a multiple of the triangle step");
  end
  logic signed [W:0] tri_q, tri_d;
  dir_e dir_q, dir_d;
  logic valley_q, valley_d, tick;
  logic [PHASE_BITS-1:0] phase_q, phase_d, freq_q, freq_d;
  logic [LEVEL_BITS-1:0] lvl_q, lvl_d, amp;
  logic [LUT_ADDR_BITS-1:0] addr;
  quad_e quad;
  logic [Q-1:0] idx_q, idx_d;
  logic neg1_q, neg1_d, neg2_q, neg2_d;
  logic [2:0] v_q, v_d;
  logic [BITS-2:0] mag;
  logic signed [BITS-1:0] samp_q, samp_d;
  logic signed [W-1:0] sine_q, sine_d;
  // S1-S3 run freely off the phase register, which only moves on a tick;
  // v_q tracks the tick so SINE loads exactly once, four cycles after VALLEY
  always_comb begin
    tick = valley_q & ENABLE;
    tri_d = tri_q;
    dir_d = dir_q;
    valley_d = 1'b0;
    if (ENABLE) begin
      tri_d = dir_q == DIR_UP ? tri_q + STEP : tri_q - STEP;
      dir_d = tri_d == TMAX ? DIR_DOWN : tri_d == -TMAX ? DIR_UP : dir_q;
      valley_d = tri_d == -TMAX;
    end
    phase_d = tick ? phase_q + freq_q : phase_q;
    freq_d = tick ? FREQ : freq_q;
    lvl_d = tick ? LEVEL : lvl_q;
    addr = phase_d[PHASE_BITS-1 -: LUT_ADDR_BITS];
    quad = quad_e'(addr[LUT_ADDR_BITS-1 -: 2]);
    idx_d = (quad == Q1 || quad == Q3) ? ~addr[Q-1:0] : addr[Q-1:0];
    neg1_d = quad == Q2 || quad == Q3;
    neg2_d = neg1_q;
    v_d = {v_q[1:0], tick};
    samp_d = neg2_q ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    sine_d = v_q[2] ? W'(samp_q) * W'($signed({1'b0, amp})) : sine_q;
  end
  ac_motor_sine_rom #(.BITS(BITS), .LUT_ADDR_BITS(LUT_ADDR_BITS)) u_rom (
    .clk(CLK), .rst(RESET), .addr(idx_q), .mag(mag)
  );
`ifdef AC_MOTOR_SOFT_START_EN
  logic [LEVEL_BITS-1:0] ramp_q, ramp_d;
  always_comb
    ramp_d = !tick ? ramp_q : ramp_q < lvl_d ? ramp_q + LEVEL_BITS'(1) :
             ramp_q > lvl_d ? ramp_q - LEVEL_BITS'(1) : ramp_q;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) ramp_q <= '0;
    else ramp_q <= ramp_d;
  assign amp = ramp_q;
`else
  assign amp = lvl_q;
`endif
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      tri_q <= -TMAX;
      dir_q <= DIR_UP;
      valley_q <= 1'b0;
      phase_q <= '0;
      freq_q <= '0;
      lvl_q <= '0;
      idx_q <= '0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      v_q <= '0;
      samp_q <= '0;
      sine_q <= '0;
    end else begin
      tri_q <= tri_d;
      dir_q <= dir_d;
      valley_q <= valley_d;
      phase_q <= phase_d;
      freq_q <= freq_d;
      lvl_q <= lvl_d;
      idx_q <= idx_d;
      neg1_q <= neg1_d;
      neg2_q <= neg2_d;
      v_q <= v_d;
      samp_q <= samp_d;
      sine_q <= sine_d;
    end
  assign TRIANGLE = tri_q;
  assign SINE = sine_q;
  assign VALLEY = valley_q & ENABLE;
endmodule

// File: tb/tb_ac_motor_reference_gen.sv
// tb_ac_motor_reference_gen: self-checking bench for the AC motor reference generator
module tb_ac_motor_reference_gen;
  localparam int TMAX = 2048, STEP = 256, PER = 32;
  logic CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b0;
  logic [23:0] FREQ = '0;
  logic [3:0] LEVEL = '0;
  logic signed [12:0] TRIANGLE;
  logic signed [11:0] SINE;
  logic VALLEY;
  int n_checks = 0, n_fail = 0;
  int n, cyc, m_sine, sh_lvl, ramp;
  longint phase, sh_freq;
  typedef struct {int due; int val;} upd_t;
  upd_t q[$];
  ac_motor_reference_gen #(.BITS(8), .LEVEL_BITS(4), .STEP_SHIFT(8)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .FREQ(FREQ), .LEVEL(LEVEL),
    .TRIANGLE(TRIANGLE), .SINE(SINE), .VALLEY(VALLEY)
  );
  always #5 CLK = ~CLK;
  function automatic int lut(int a);
    int qd, i, m;
    qd = a / 64;
    i = a % 64;
    if (qd % 2 == 1) i = 63 - i;
    m = $rtoi(127.0 * $sin(3.14159265358979 / 2.0 * (i + 0.5) / 64.0) + 0.5);
    return qd >= 2 ? -m : m;
  endfunction
  function automatic int tri_of(int k);
    int p;
    p = k % PER;
    return p <= 16 ? -TMAX + STEP * p : TMAX - STEP * (p - 16);
  endfunction
  function automatic int valley_now();
    return (n > 0 && n % PER == 0 && ENABLE) ? 1 : 0;
  endfunction
  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    n = 0; phase = 0; sh_freq = 0; sh_lvl = 0; ramp = 0; m_sine = 0;
    q.delete();
  endtask
  task automatic step();
    int a;
    @(posedge CLK);
    cyc++;
    if (RESET) model_reset();
    else begin
      if (valley_now() == 1) begin
        phase = (phase + sh_freq) % (longint'(1) << 24);
        sh_freq = longint'(FREQ);
        sh_lvl = int'(LEVEL);
        ramp += ramp < sh_lvl ? 1 : ramp > sh_lvl ? -1 : 0;
`ifdef AC_MOTOR_SOFT_START_EN
        a = ramp;
`else
        a = sh_lvl;
`endif
        q.push_back('{cyc + 3, lut(int'(phase >> 16)) * a});
      end
      if (ENABLE) n++;
      if (q.size() > 0 && q[0].due == cyc) m_sine = q.pop_front().val;
    end
    #1;
    chk("triangle", $signed(TRIANGLE), tri_of(n));
    chk("valley", VALLEY, valley_now());
    chk("sine", $signed(SINE), m_sine);
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    #2 RESET = 1'b0;
  endtask
  initial begin
    int exp_q[4];
`ifdef AC_MOTOR_SOFT_START_EN
    exp_q = '{2, 254, -6, -508};
`else
    exp_q = '{30, 1905, -30, -1905};
`endif
    model_reset();
    cyc = 0;
    do_reset();
    FREQ = 24'h400000;
    LEVEL = 4'd0;
    ENABLE = 1'b1;
    repeat (3 * PER + 5) step();
    do_reset();
    LEVEL = 4'd15;
    for (int k = 1; k <= 4; k++) begin
      while (n != PER * k + 4) step();
      chk("quarter", $signed(SINE), exp_q[k - 1]);
    end
    while (n % PER != 16) step();
    LEVEL = 4'd7;
    repeat (2 * PER) step();
    for (int k = 0; k < 6 * PER; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        FREQ = 24'($urandom);
        LEVEL = 4'($urandom_range(0, 15));
      end
      step();
    end
    while (n % PER != 10) step();
    chk("freeze_start", $signed(TRIANGLE), 512);
    ENABLE = 1'b0;
    repeat (10) step();
    chk("freeze_hold", $signed(TRIANGLE), 512);
    ENABLE = 1'b1;
    FREQ = 24'h400000;
    LEVEL = 4'd15;
    repeat (3 * PER) step();
    while (n % PER != 20) step();
    #2 RESET = 1'b1;
    #1;
    chk("async_tri", $signed(TRIANGLE), -TMAX);
    chk("async_sine", $signed(SINE), 0);
    chk("async_valley", VALLEY, 0);
    model_reset();
    step();
    #2 RESET = 1'b0;
    repeat (2 * PER + 8) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
